udp_packet_scheduler: RTL and testbench

- Sequences the ADC sample path between the 48-bit sample FIFO and the wiznet5500 TX interface.
- Pops one FIFO word at a time and pushes it to the Ethernet module when it is available.
- Issues a flush (UDP send) after LENGTH_UDP words, after an idle timeout on a partial packet, or when the stream is disabled.
- Replaces the ad-hoc glue logic at top level. Exports packet and partial-flush counters for debug.

---
 rtl/udp_packet_scheduler.sv | 135 +++++++++++++
 tb/tb_udp_packet_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_packet_scheduler.sv
// Moves 48-bit ADC samples from the sample FIFO to the wiznet5500 TX path one word
// at a time, and issues UDP sends on a full packet, on an idle timeout, or when the stream is disabled.
module udp_packet_scheduler #(
    parameter logic [8:0]  LENGTH_UDP     = 9'd245,
    parameter int unsigned DATA_W         = 48,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd50000,
    parameter logic [3:0]  MIN_GAP        = 4'd8,
    parameter logic [2:0]  FETCH_WAIT     = 3'd4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_data_out_valid,
    output logic              fifo_read_enabled,
    input  logic              ethernet_available,
    output logic [DATA_W-1:0] data_to_ethernet,
    output logic              data_out_valid,
    output logic              flush_requested,
    output logic [8:0]        word_count,
    output logic [15:0]       packets_sent,
    output logic [15:0]       partial_flushes
);

    typedef enum logic [2:0] {IDLE, FETCH, PUSH, FLUSH, HOLDOFF} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] buffer;
    logic [23:0]       timer;
    logic [3:0]        cnt;
    logic              go_full, go_partial, go_read;
    logic              do_push, do_flush, fetch_miss, gap_done;
    logic              read_d, valid_d, flush_d;

    assign go_full    = (word_count == LENGTH_UDP);
    assign go_partial = (word_count != 9'd0) && ((timer == TIMEOUT_CYCLES) || !enable);
    assign go_read    = enable && !fifo_empty;
    assign do_push    = (state == PUSH) && ethernet_available;
    assign do_flush   = (state == FLUSH) && ethernet_available;
    assign fetch_miss = (5'({1'b0, cnt}) + 5'd1) >= 5'({2'b00, FETCH_WAIT});
    assign gap_done   = (5'({1'b0, cnt}) + 5'd1) >= 5'({1'b0, MIN_GAP});

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; IDLE decisions are in priority order full > partial > read
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go_full || go_partial) begin
                    state_next = FLUSH;
                end else if (go_read) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (fifo_data_out_valid) begin
                    state_next = PUSH;
                end else if (fetch_miss) begin
                    state_next = IDLE;
                end
            end
            PUSH:    if (ethernet_available) state_next = IDLE;
            FLUSH:   if (ethernet_available) state_next = HOLDOFF;
            HOLDOFF: if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe decode; each strobe belongs to a distinct state so they are mutually exclusive
    always_comb begin
        read_d  = 1'b0;
        valid_d = 1'b0;
        flush_d = 1'b0;
        if (state == IDLE && !go_full && !go_partial && go_read) begin
            read_d = 1'b1;
        end
        if (do_push) begin
            valid_d = 1'b1;
        end
        if (do_flush) begin
            flush_d = 1'b1;
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt               <= 4'd0;
            buffer            <= '0;
            timer             <= 24'd0;
            fifo_read_enabled <= 1'b0;
            data_out_valid    <= 1'b0;
            flush_requested   <= 1'b0;
            data_to_ethernet  <= '0;
            word_count        <= 9'd0;
            packets_sent      <= 16'd0;
            partial_flushes   <= 16'd0;
        end else begin
            cnt               <= (state_next != state) ? 4'd0 : cnt + 4'd1;
            fifo_read_enabled <= read_d;
            data_out_valid    <= valid_d;
            flush_requested   <= flush_d;
            if (state == FETCH && fifo_data_out_valid) begin
                buffer <= fifo_data_out;
            end
            if (do_push) begin
                data_to_ethernet <= buffer;
                word_count       <= word_count + 9'd1;
            end else if (do_flush) begin
                word_count   <= 9'd0;
                packets_sent <= packets_sent + 16'd1;
                if (word_count != LENGTH_UDP) begin
                    partial_flushes <= partial_flushes + 16'd1;
                end
            end
            // Idle timer only runs while a partial packet is waiting for more data
            if (do_push || word_count == 9'd0) begin
                timer <= 24'd0;
            end else if ((state == IDLE || state == FETCH) && word_count < LENGTH_UDP
                         && timer < TIMEOUT_CYCLES) begin
                timer <= timer + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_packet_scheduler.sv
// Scoreboard bench for udp_packet_scheduler: a FIFO model feeds words, a negedge monitor
// pops expected words/flushes in order; directed phases check counters and timing.
module tb_udp_packet_scheduler;

    localparam int unsigned DATA_W = 48;

    typedef struct {
        bit                is_flush;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data_out = '0;
    logic              fifo_data_out_valid = 1'b0;
    logic              fifo_read_enabled;
    logic              ethernet_available = 1'b1;
    logic [DATA_W-1:0] data_to_ethernet;
    logic              data_out_valid;
    logic              flush_requested;
    logic [8:0]        word_count;
    logic [15:0]       packets_sent;
    logic [15:0]       partial_flushes;

    udp_packet_scheduler #(
        .LENGTH_UDP(9'd4),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(24'd100),
        .MIN_GAP(4'd8),
        .FETCH_WAIT(3'd4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_data_out_valid(fifo_data_out_valid),
        .fifo_read_enabled(fifo_read_enabled),
        .ethernet_available(ethernet_available),
        .data_to_ethernet(data_to_ethernet),
        .data_out_valid(data_out_valid),
        .flush_requested(flush_requested),
        .word_count(word_count),
        .packets_sent(packets_sent),
        .partial_flushes(partial_flushes)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_reads = 0, n_words = 0, n_flush = 0;
    int last_read_cyc = 0, last_push_cyc = 0, last_flush_cyc = 0;
    bit check_lat = 0;
    bit suppress = 0;
    logic [DATA_W-1:0] fifo_q[$];
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // FIFO model: data valid one cycle after the read strobe
    always @(posedge clk) begin
        fifo_data_out_valid <= 1'b0;
        if (reset_n && fifo_read_enabled && !suppress && fifo_q.size() > 0) begin
            fifo_data_out       <= fifo_q.pop_front();
            fifo_data_out_valid <= 1'b1;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            int strobes;
            strobes = int'(fifo_read_enabled) + int'(data_out_valid) + int'(flush_requested);
            if (strobes > 0) check_range("strobe_exclusive", strobes, 1, 1);
            if (fifo_read_enabled) begin
                n_reads++;
                last_read_cyc = cyc;
            end
            if (data_out_valid) begin
                if (check_lat) begin
                    check("read_to_valid_latency", cyc - last_read_cyc, 3);
                    if (n_words > 0 && (n_words % 4) != 0)
                        check("word_spacing", cyc - last_push_cyc, 4);
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", data_to_ethernet);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_kind", longint'(e.is_flush), 0);
                    check("word_data", longint'(data_to_ethernet), longint'(e.data));
                end
                n_words++;
                last_push_cyc = cyc;
            end
            if (flush_requested) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_flush: got flush expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("flush_kind", longint'(e.is_flush), 1);
                end
                n_flush++;
                last_flush_cyc = cyc;
            end
        end
    end

    task automatic queue_word(input logic [DATA_W-1:0] d, input bit expect_it);
        exp_t e;
        fifo_q.push_back(d);
        if (expect_it) begin
            e.is_flush = 0; e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_flush();
        exp_t e;
        e.is_flush = 1; e.data = '0;
        exp_q.push_back(e);
    endtask

    function automatic int get_count(input int sel);
        if (sel == 0) return n_reads;
        if (sel == 1) return n_words;
        return n_flush;
    endfunction

    // Bounded wait until counter sel (0 reads, 1 words, 2 flushes) reaches target
    task automatic wait_count(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (get_count(sel) < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (get_count(sel) < target) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d expected %0d", name, get_count(sel), target);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int r0, w0, f0, c1;

        // Reset state
        idle_cycles(3);
        check("rst_read", longint'(fifo_read_enabled), 0);
        check("rst_valid", longint'(data_out_valid), 0);
        check("rst_flush", longint'(flush_requested), 0);
        check("rst_data", longint'(data_to_ethernet), 0);
        check("rst_word_count", longint'(word_count), 0);
        check("rst_packets", longint'(packets_sent), 0);
        check("rst_partial", longint'(partial_flushes), 0);
        reset_n = 1'b1;
        idle_cycles(3);

        // Full packet of 4 words
        check_lat = 1;
        queue_word(48'hA0000000_0001, 1); queue_word(48'hA0000000_0002, 1);
        queue_word(48'hA0000000_0003, 1); queue_word(48'hA0000000_0004, 1);
        expect_flush();
        enable = 1'b1;
        wait_count(2, 1, 200, "full_flush");
        check_lat = 0;
        check("full_packets", longint'(packets_sent), 1);
        check("full_partial", longint'(partial_flushes), 0);
        check("full_word_count", longint'(word_count), 0);
        idle_cycles(12);

        // Idle timeout on a 2-word packet
        queue_word(48'hB0000000_0011, 1); queue_word(48'hB0000000_0012, 1);
        expect_flush();
        wait_count(2, 2, 300, "timeout_flush");
        check_range("timeout_gap", last_flush_cyc - last_push_cyc, 98, 102);
        check("timeout_partial", longint'(partial_flushes), 1);
        check("timeout_packets", longint'(packets_sent), 2);
        check("timeout_word_count", longint'(word_count), 0);
        idle_cycles(12);

        // Back-pressure in PUSH
        ethernet_available = 1'b0;
        r0 = n_reads; w0 = n_words;
        queue_word(48'hC0FFEE_123456, 1);
        expect_flush();
        idle_cycles(50);
        check("bp_no_push", n_words, w0);
        check("bp_single_read", n_reads, r0 + 1);
        ethernet_available = 1'b1;
        wait_count(1, w0 + 1, 10, "bp_word");
        idle_cycles(5);
        check("bp_data_hold", longint'(data_to_ethernet), longint'(48'hC0FFEE_123456));
        check("bp_read_total", n_reads, r0 + 1);
        wait_count(2, 3, 200, "bp_flush");
        check("bp_partial", longint'(partial_flushes), 2);
        idle_cycles(12);

        // Drain: disable after 3 of 4 words
        w0 = n_words; f0 = n_flush;
        queue_word(48'hD0000000_0001, 1); queue_word(48'hD0000000_0002, 1);
        queue_word(48'hD0000000_0003, 1); queue_word(48'hD0000000_0004, 0);
        expect_flush();
        wait_count(1, w0 + 3, 60, "drain_words");
        enable = 1'b0;
        r0 = n_reads;
        wait_count(2, f0 + 1, 20, "drain_flush");
        check("drain_flush_delay", last_flush_cyc - last_push_cyc, 2);
        idle_cycles(10);
        check("drain_no_reads", n_reads, r0);
        check("drain_word_count", longint'(word_count), 0);
        check("drain_partial", longint'(partial_flushes), 3);
        check("drain_packets", longint'(packets_sent), 4);
        fifo_q.delete();
        idle_cycles(2);
        enable = 1'b1;
        idle_cycles(10);

        // Fetch miss: strobe without data returns to IDLE after 4 cycles
        suppress = 1;
        r0 = n_reads; w0 = n_words; f0 = n_flush;
        queue_word(48'hE0000000_0001, 1);
        expect_flush();
        wait_count(0, r0 + 1, 20, "miss_read1");
        c1 = last_read_cyc;
        wait_count(0, r0 + 2, 20, "miss_read2");
        check("miss_retry_interval", last_read_cyc - c1, 5);
        check("miss_word_count", longint'(word_count), 0);
        check("miss_no_push", n_words, w0);
        suppress = 0;
        wait_count(1, w0 + 1, 20, "miss_word");
        wait_count(2, f0 + 1, 200, "miss_flush");
        check("miss_partial", longint'(partial_flushes), 4);
        idle_cycles(12);

        // Async reset mid-packet
        w0 = n_words;
        queue_word(48'hF0000000_0001, 1); queue_word(48'hF0000000_0002, 1);
        queue_word(48'hF0000000_0003, 0);
        wait_count(1, w0 + 2, 40, "rstmid_words");
        check("rstmid_word_count_before", longint'(word_count), 2);
        reset_n = 1'b0;
        #1;
        check("rstmid_word_count", longint'(word_count), 0);
        check("rstmid_packets", longint'(packets_sent), 0);
        check("rstmid_partial", longint'(partial_flushes), 0);
        check("rstmid_data", longint'(data_to_ethernet), 0);
        fifo_q.delete();
        f0 = n_flush;
        idle_cycles(4);
        reset_n = 1'b1;
        idle_cycles(20);
        check("rstmid_no_flush", n_flush, f0);
        queue_word(48'h123456_000001, 1); queue_word(48'h123456_000002, 1);
        queue_word(48'h123456_000003, 1); queue_word(48'h123456_000004, 1);
        expect_flush();
        wait_count(2, f0 + 1, 200, "rstmid_full_flush");
        check("rstmid_full_packets", longint'(packets_sent), 1);
        check("rstmid_full_partial", longint'(partial_flushes), 0);
        idle_cycles(12);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
